// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - shared constants and types for the shift unit arbiter
package shift_arb_pkg;

   localparam int SHIFT_DATA_W  = 32;
   localparam int SHIFT_SHAMT_W = 5;
   localparam int SHIFT_N_REQ   = 4;

   localparam logic SHIFT_DIR_LEFT  = 1'b0;
   localparam logic SHIFT_DIR_RIGHT = 1'b1;

   localparam logic SHIFT_LOGICAL = 1'b0;
   localparam logic SHIFT_ARITH   = 1'b1;

   // Output register occupancy; res_valid is simply "state == RES_FULL".
   typedef enum logic {
      RES_EMPTY = 1'b0,
      RES_FULL  = 1'b1
   } res_state_e;

   // Round-robin successor of an index in a ring of n entries.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - combinational log-stage barrel shifter (left, right logical, right arithmetic)
module barrel_shifter
   import shift_arb_pkg::*;
#(
   parameter int DATA_W  = SHIFT_DATA_W,
   parameter int SHAMT_W = SHIFT_SHAMT_W
) (
   input  logic [DATA_W-1:0]  data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic               dir_i,
   input  logic               arith_i,
   output logic [DATA_W-1:0]  result_o
);

   // Fill bit only differs from zero for an arithmetic right shift.
   logic fill;
   assign fill = (dir_i == SHIFT_DIR_RIGHT) && (arith_i == SHIFT_ARITH) && data_i[DATA_W-1];

   logic [DATA_W-1:0] stage [SHAMT_W+1];
   assign stage[0] = data_i;

   // Stage s shifts by 2**s when shamt bit s is set.
   for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
      localparam int SH = 1 << s;
      assign stage[s+1] = !shamt_i[s]                ? stage[s] :
                          (dir_i == SHIFT_DIR_RIGHT) ? {{SH{fill}}, stage[s][DATA_W-1:SH]} :
                                                       {stage[s][DATA_W-1-SH:0], {SH{1'b0}}};
   end

   assign result_o = stage[SHAMT_W];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant generator starting its search at a pointer
module rr_arbiter
   import shift_arb_pkg::*;
#(
   parameter int N     = SHIFT_N_REQ,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   input  logic             en_i,
   output logic [N-1:0]     grant_o,
   output logic [PTR_W-1:0] grant_idx_o
);

   logic found;

   // Scan from ptr_i upward with wrap; the first active request wins.
   always_comb begin
      int idx;
      idx         = 0;
      found       = 1'b0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_i) + k) % N;
         if (!found && req_i[idx]) begin
            found       = 1'b1;
            grant_idx_o = PTR_W'(idx);
         end
      end
      if (en_i && found) begin
         grant_o[grant_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - shares one barrel shifter among N_REQ requesters with a registered result
module shift_unit_arbiter
   import shift_arb_pkg::*;
#(
   parameter int N_REQ   = SHIFT_N_REQ,
   parameter int DATA_W  = SHIFT_DATA_W,
   parameter int SHAMT_W = SHIFT_SHAMT_W,
   parameter int ID_W    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   input  logic [N_REQ*SHAMT_W-1:0]   req_shamt,
   input  logic [N_REQ-1:0]           req_dir,
   input  logic [N_REQ-1:0]           req_arith,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [DATA_W-1:0]          res_data,
   output logic [ID_W-1:0]            res_id
);

   res_state_e        state_q, state_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic              can_accept;
   logic              arb_en;
   logic              accept;
   logic [ID_W-1:0]   gnt_idx;

   logic [DATA_W-1:0]  op_data;
   logic [SHAMT_W-1:0] op_shamt;
   logic               op_dir;
   logic               op_arith;
   logic [DATA_W-1:0]  shift_res;

   assign res_valid = (state_q == RES_FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

   // The register can take a new result when empty or when it drains this cycle;
   // grants are suppressed while reset is asserted.
   assign can_accept = !res_valid || res_ready;
   assign arb_en     = can_accept && !rst;

   rr_arbiter #(
      .N     (N_REQ),
      .PTR_W (ID_W)
   ) u_arb (
      .req_i       (req_valid),
      .ptr_i       (rr_ptr_q),
      .en_i        (arb_en),
      .grant_o     (req_ready),
      .grant_idx_o (gnt_idx)
   );

   assign accept = |(req_valid & req_ready);

   // Route the granted requester's operands onto the shared shifter.
   always_comb begin
      op_data  = '0;
      op_shamt = '0;
      op_dir   = SHIFT_DIR_LEFT;
      op_arith = SHIFT_LOGICAL;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            op_data  = req_data[i*DATA_W +: DATA_W];
            op_shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
            op_dir   = req_dir[i];
            op_arith = req_arith[i];
         end
      end
   end

   barrel_shifter #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_shift (
      .data_i   (op_data),
      .shamt_i  (op_shamt),
      .dir_i    (op_dir),
      .arith_i  (op_arith),
      .result_o (shift_res)
   );

   // Next-state for occupancy, result payload and round-robin pointer.
   always_comb begin
      state_d    = state_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         RES_EMPTY: begin
            if (accept) state_d = RES_FULL;
         end
         RES_FULL: begin
            if (accept)         state_d = RES_FULL;
            else if (res_ready) state_d = RES_EMPTY;
         end
         default: state_d = RES_EMPTY;
      endcase
      if (accept) begin
         res_data_d = shift_res;
         res_id_d   = gnt_idx;
         rr_ptr_d   = ID_W'(rr_next(int'(gnt_idx), N_REQ));
      end
   end

   // Result register and pointer, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RES_EMPTY;
         res_data_q <= '0;
         res_id_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - randomized self-checking bench for shift_unit_arbiter
module tb_shift_unit_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = 5;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_data;
   logic [N*SW-1:0] req_shamt;
   logic [N-1:0]    req_dir = '0;
   logic [N-1:0]    req_arith = '0;
   logic            res_valid;
   logic            res_ready = 1'b1;
   logic [DW-1:0]   res_data;
   logic [IW-1:0]   res_id;

   logic [DW-1:0]   op_d [N];
   logic [SW-1:0]   op_s [N];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit            m_valid = 1'b0;
   logic [DW-1:0] m_data  = '0;
   int            m_id    = 0;
   int            m_ptr   = 0;
   logic [N-1:0]  m_grant = '0;
   logic [N-1:0]  obs_ready = '0;

   always #5 clk = ~clk;

   always_comb begin
      req_data  = '0;
      req_shamt = '0;
      for (int i = 0; i < N; i++) begin
         req_data[i*DW +: DW]  = op_d[i];
         req_shamt[i*SW +: SW] = op_s[i];
      end
   end

   shift_unit_arbiter #(
      .N_REQ   (N),
      .DATA_W  (DW),
      .SHAMT_W (SW),
      .ID_W    (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_shamt (req_shamt),
      .req_dir   (req_dir),
      .req_arith (req_arith),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   // Requester obligation: a pending request stays valid with stable operands.
   logic [N-1:0]  pend_q = '0;
   logic [DW-1:0] pd_q [N];
   logic [SW-1:0] ps_q [N];
   logic [N-1:0]  pdir_q = '0;
   logic [N-1:0]  par_q = '0;
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (pend_q[i] && !rst) begin
            assert (req_valid[i] && op_d[i] == pd_q[i] && op_s[i] == ps_q[i] &&
                    req_dir[i] == pdir_q[i] && req_arith[i] == par_q[i])
               else $error("requester %0d changed a pending request", i);
         end
         pd_q[i] <= op_d[i];
         ps_q[i] <= op_s[i];
      end
      pdir_q <= req_dir;
      par_q  <= req_arith;
      pend_q <= rst ? '0 : (req_valid & ~req_ready);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                               input logic dr, input logic ar);
      if (!dr)     return d << s;
      else if (ar) return DW'($signed(d) >>> s);
      else         return d >> s;
   endfunction

   function automatic int find_cand();
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // One clock: check grants before the edge, advance the model, check outputs after.
   task automatic tick();
      int cand;
      #1;
      cand    = find_cand();
      m_grant = '0;
      if (!rst && (!m_valid || res_ready) && cand >= 0) m_grant[cand] = 1'b1;
      obs_ready = req_ready;
      check("req_ready", 64'(req_ready), 64'(m_grant));
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
      end else if (m_grant != '0) begin
         m_data  = ref_shift(op_d[cand], op_s[cand], req_dir[cand], req_arith[cand]);
         m_id    = cand;
         m_valid = 1'b1;
         m_ptr   = (cand + 1) % N;
      end else if (m_valid && res_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #2;
      check("res_valid", 64'(res_valid), 64'(m_valid));
      check("res_data", 64'(res_data), 64'(m_data));
      check("res_id", 64'(res_id), 64'(m_id));
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input logic dr, input logic ar);
      op_d[i]      = d;
      op_s[i]      = s;
      req_dir[i]   = dr;
      req_arith[i] = ar;
   endtask

   task automatic rand_req(input int i);
      logic [DW-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : DW'($urandom);
      set_req(i, d, SW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      for (int i = 0; i < N; i++) set_req(i, '0, '0, 1'b0, 1'b0);
      rst = 1'b1; req_valid = '0; res_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_data", 64'(res_data), 64'd0);
      check("rst_id", 64'(res_id), 64'd0);

      // Single left shift from requester 1
      set_req(1, 32'h0000_00F0, 5'd4, 1'b0, 1'b0);
      req_valid = 4'b0010;
      tick();
      check("single_valid", 64'(res_valid), 64'd1);
      check("single_data", 64'(res_data), 64'h0000_0F00);
      check("single_id", 64'(res_id), 64'd1);
      req_valid = '0;

      // Arithmetic vs logical right shift by 31
      set_req(2, 32'h8000_0000, 5'd31, 1'b1, 1'b1);
      req_valid = 4'b0100;
      tick();
      check("sra31", 64'(res_data), 64'hFFFF_FFFF);
      req_valid = '0;
      set_req(3, 32'h8000_0000, 5'd31, 1'b1, 1'b0);
      req_valid = 4'b1000;
      tick();
      check("srl31", 64'(res_data), 64'h0000_0001);
      req_valid = '0;

      // All four continuously from pointer 0; requester 2 carries the held value later
      rand_req(0); rand_req(1); rand_req(3);
      set_req(2, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("rr_id", 64'(res_id), 64'(k % 4));
         check("rr_valid", 64'(res_valid), 64'd1);
      end

      // Backpressure with id 2 held, then drain+accept of requester 3
      tick();
      check("bp_load_data", 64'(res_data), 64'h1234_5678);
      check("bp_load_id", 64'(res_id), 64'd2);
      res_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_hold_ready", 64'(obs_ready), 64'd0);
         check("bp_hold_data", 64'(res_data), 64'h1234_5678);
         check("bp_hold_id", 64'(res_id), 64'd2);
      end
      res_ready = 1'b1;
      tick();
      check("bp_grant", 64'(obs_ready), 64'b1000);
      check("bp_next_id", 64'(res_id), 64'd3);
      check("bp_next_valid", 64'(res_valid), 64'd1);

      // Drain pending requesters, park pointer at 2, then a lone request from 0
      req_valid = 4'b0111;
      tick(); req_valid = 4'b0110;
      tick(); req_valid = 4'b0100;
      tick(); req_valid = 4'b0000;
      rand_req(1);
      req_valid = 4'b0010;
      tick(); req_valid = 4'b0000;
      set_req(0, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1);
      req_valid = 4'b0001;
      tick();
      check("wrap_grant", 64'(obs_ready), 64'b0001);
      check("shamt0_data", 64'(res_data), 64'hDEAD_BEEF);
      check("wrap_id", 64'(res_id), 64'd0);
      for (int i = 0; i < N; i++) rand_req(i);
      req_valid = 4'b1111;
      tick();
      check("ptr_after_wrap", 64'(res_id), 64'd1);

      // Reset while a result is held and requests are pending
      res_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("midrst_ready", 64'(obs_ready), 64'd0);
      check("midrst_valid", 64'(res_valid), 64'd0);
      check("midrst_data", 64'(res_data), 64'd0);
      check("midrst_id", 64'(res_id), 64'd0);
      rst = 1'b0;
      res_ready = 1'b1;
      tick();
      check("restart_id", 64'(res_id), 64'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || m_grant[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  req_valid[i] = 1'b1;
                  rand_req(i);
               end else begin
                  req_valid[i] = 1'b0;
               end
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_unit_arbiter.md
# shift_unit_arbiter

Shares one combinational barrel shifter datapath among `N_REQ` independent requesters. Uses round-robin arbitration with valid/ready handshakes on every request port. Registers each shift result together with the ID of the requester that produced it. Sits between the ALU issue logic and the shared shift resource, so several execution lanes can use one shifter at up to one operation per cycle.

## Interface
- `N_REQ`, default 4: number of requesters; must be at least 2.
- `DATA_W`, default 32: operand and result width.
- `SHAMT_W`, default 5: shift-amount width; must equal clog2(`DATA_W`).
- `ID_W`, default 2: requester ID width; must equal clog2(`N_REQ`).
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high per cycle.
- `req_data`  in  N_REQ*DATA_W  packed operands; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_shamt`  in  N_REQ*SHAMT_W  packed shift amounts.
- `req_dir`  in  N_REQ  0 = left shift, 1 = right shift.
- `req_arith`  in  N_REQ  0 = logical shift, 1 = arithmetic shift.
- `res_valid`  out  1  result register holds a valid result.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  DATA_W  shifted result.
- `res_id`  out  ID_W  index of the requester that produced `res_data`.

## Operation
- Output register state is either EMPTY (`res_valid` = 0) or FULL (`res_valid` = 1). There is no other FSM.
- `can_accept` = !`res_valid` | `res_ready`.
- Grant selection:
  - Search begins at pointer `rr_ptr` and wraps modulo N_REQ.
  - The first requester with `req_valid` high is the candidate.
  - `req_ready[g]` = `can_accept` & candidate exists & (i == g). All other ready bits are 0.
  - Ready is combinational from `req_valid`, `res_valid`, `res_ready` and `rr_ptr`.
- Accept event occurs when `req_valid[g]` & `req_ready[g]`. On that clock edge:
  - `res_data` <= shift of `req_data[g]` by `req_shamt[g]` per `req_dir[g]` / `req_arith[g]`.
  - `res_id` <= g; `res_valid` <= 1.
  - `rr_ptr` <= (g+1) mod N_REQ.
- Drain without accept (`res_valid` & `res_ready`, no accept): `res_valid` <= 0. `res_data` and `res_id` hold their old values.
- Simultaneous drain and accept: the new result replaces the old one and `res_valid` stays 1. This gives full throughput.
- Hold (`res_valid` & !`res_ready`): `res_valid`, `res_data` and `res_id` are stable. All `req_ready` bits are 0.
- `rr_ptr` changes only on an accept event.
- Shift semantics:
  - Left shift fills with zeros for both logical and arithmetic (arithmetic left == logical left).
  - Right logical fills with zeros.
  - Right arithmetic replicates `req_data` MSB.
  - Shift amount 0 passes the operand unchanged. Every `SHAMT_W` value is in range.
- Requester obligation: once `req_valid` is high, the requester holds `req_valid` and its operands stable until it sees `req_ready`. A requester that violates this has undefined results; the bench includes an assertion for it.

## Timing
- Latency: 1 cycle. A request accepted at edge k produces `res_valid` = 1 and the result after edge k.
- Throughput: 1 result per cycle while `res_ready` = 1.
- Reset values: `res_valid` = 0, `res_data` = 0, `res_id` = 0, `rr_ptr` = 0.
- `req_ready` is all-zero during reset.
- Reset mid-operation discards any held result. No partial state survives.
- Fairness: under continuous requests from k requesters, each is granted once every k accepts. Maximum wait is N_REQ-1 accepts.
- There are no combinational paths from `res_ready` to `res_valid`, `res_data` or `res_id`. The path from `res_ready` to `req_ready` is permitted.

## Structure
- Package `shift_arb_pkg` holds:
  - default constants `SHIFT_DATA_W` = 32, `SHIFT_SHAMT_W` = 5, `SHIFT_N_REQ` = 4;
  - direction encodings `SHIFT_DIR_LEFT` = 0, `SHIFT_DIR_RIGHT` = 1;
  - type encodings `SHIFT_LOGICAL` = 0, `SHIFT_ARITH` = 1.
- Datapath: one instance of the team's existing `barrel_shifter` module, fed by muxed operands of the granted requester.
- Natural sub-module: `rr_arbiter`, a parameterised round-robin grant generator.
  - Inputs: `req` vector, `rr_ptr`, enable (`can_accept`).
  - Output: one-hot `grant`.
  - Also reused by other shared-resource controllers.
- Top-level responsibilities: operand mux, result register, pointer update.

## Test plan
- Reset, then single request: requester 1 sends `req_data` = 0x0000_00F0, shamt = 4, dir = 0, arith = 0, with `res_ready` = 1 → next cycle `res_valid` = 1, `res_data` = 0x0000_0F00, `res_id` = 1.
- Arithmetic vs logical right shift of 0x8000_0000 by 31 → `res_data` = 0xFFFF_FFFF for arith = 1, 0x0000_0001 for arith = 0.
- All 4 requesters valid continuously from `rr_ptr` = 0, `res_ready` = 1 → `res_id` sequence is 0, 1, 2, 3, 0, 1; one result per cycle.
- Backpressure: `res_ready` = 0 for 3 cycles while result 0x1234_5678 with id 2 is held → output stays stable and all `req_ready` = 0. When `res_ready` = 1, the next grant is requester 3, and the drain and accept happen on the same edge.
- Sparse requests: only requester 0 valid while `rr_ptr` = 2 → grant wraps to 0 and `rr_ptr` becomes 1. Shamt = 0 on 0xDEAD_BEEF → `res_data` = 0xDEAD_BEEF.
- Assert `rst` while `res_valid` = 1 and requests are pending → next cycle `res_valid` = 0, `res_data` = 0, `res_id` = 0, `req_ready` = 0; arbitration restarts from requester 0.
